// File: rtl/delta_decoder.sv
// delta_decoder: decodes 1,0,0,1 trigger headers, counts triggers/errors and measures inter-header gaps
module delta_decoder #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_live,
  input  logic             in_ena,
  input  logic             trig_in,
  output logic             trig_out,
  output logic             hdr_err,
  output logic [CNT_W-1:0] trig_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [GAP_W-1:0] last_gap,
  output logic             gap_valid
);
  typedef enum logic [1:0] {IDLE, S1, S10, S100} state_t;
  state_t r_state, w_next;
  logic w_clr, w_valid, w_err, w_idle0;
  logic r_trig, r_err, r_gap_valid, r_prior;
  logic [CNT_W-1:0] r_trig_cnt, r_err_cnt;
  logic [GAP_W-1:0] r_last_gap, r_gap_run;
  assign w_clr = reset || !in_live;
  always_comb begin
    w_next  = IDLE;
    w_valid = 1'b0;
    w_err   = 1'b0;
    w_idle0 = 1'b0;
    if (in_ena)
      case (r_state)
        IDLE: begin
          w_next  = trig_in ? S1 : IDLE;
          w_idle0 = !trig_in;
        end
        S1: begin
          w_next = trig_in ? S1 : S10;
          w_err  = trig_in;
        end
        S10: begin
          w_next = trig_in ? S1 : S100;
          w_err  = trig_in;
        end
        S100: begin
          w_next  = IDLE;
          w_valid = trig_in;
          w_err   = !trig_in;
        end
      endcase
  end
  always_ff @(posedge clk)
    r_state <= w_clr ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_trig      <= 1'b0;
      r_err       <= 1'b0;
      r_trig_cnt  <= '0;
      r_err_cnt   <= '0;
      r_last_gap  <= '0;
      r_gap_valid <= 1'b0;
      r_prior     <= 1'b0;
      r_gap_run   <= '0;
    end else begin
      r_trig <= w_valid;
      r_err  <= w_err;
      if (w_valid && !(&r_trig_cnt))
        r_trig_cnt <= r_trig_cnt + CNT_W'(1);
      if (w_err && !(&r_err_cnt))
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      // The first valid header after a clear only arms the measurement
      if (w_valid && r_prior) begin
        r_last_gap  <= r_gap_run;
        r_gap_valid <= 1'b1;
      end
      if (w_valid)
        r_prior <= 1'b1;
      r_gap_run <= (!in_ena || w_valid || w_err) ? '0 :
                   (w_idle0 && !(&r_gap_run)) ? r_gap_run + GAP_W'(1) : r_gap_run;
    end
  end
  assign trig_out  = r_trig;
  assign hdr_err   = r_err;
  assign trig_cnt  = r_trig_cnt;
  assign err_cnt   = r_err_cnt;
  assign last_gap  = r_last_gap;
  assign gap_valid = r_gap_valid;
endmodule

// File: tb/tb_delta_decoder.sv
// tb_delta_decoder: randomized and directed checks of delta_decoder against a header-matching reference model
module tb_delta_decoder;
  localparam int CNT_W = 8;
  localparam int GAP_W = 5;
  localparam int VW = 2 * CNT_W + GAP_W + 3;
  logic clk = 1'b0;
  logic reset = 1'b1, in_live = 1'b0, in_ena = 1'b0, trig_in = 1'b0;
  logic trig_out, hdr_err, gap_valid;
  logic [CNT_W-1:0] trig_cnt, err_cnt;
  logic [GAP_W-1:0] last_gap;
  int n_checks = 0, n_errors = 0;
  logic m_trig, m_err, m_gv, m_prior;
  logic [CNT_W-1:0] m_tc, m_ec;
  logic [GAP_W-1:0] m_lg, m_gap;
  bit cand[$];
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [VW-1:0] act_v, exp_v;
  assign act_v = {trig_out, hdr_err, trig_cnt, err_cnt, last_gap, gap_valid};
  assign exp_v = {m_trig, m_err, m_tc, m_ec, m_lg, m_gv};
  delta_decoder #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .reset(reset), .in_live(in_live), .in_ena(in_ena), .trig_in(trig_in),
    .trig_out(trig_out), .hdr_err(hdr_err), .trig_cnt(trig_cnt), .err_cnt(err_cnt),
    .last_gap(last_gap), .gap_valid(gap_valid)
  );
  always #5 clk = ~clk;
  // Reference: a candidate header is the list of bits since its leading 1; it is
  // valid when it spells 1,0,0,1 and malformed as soon as it stops being a prefix of it.
  task automatic stepx(input bit b, input bit live, input bit ena, input bit rst);
    bit ok;
    trig_in = b; in_live = live; in_ena = ena; reset = rst;
    @(posedge clk);
    if (rst || !live) begin
      {m_trig, m_err, m_gv, m_prior, m_tc, m_ec, m_lg, m_gap} = '0;
      cand.delete();
    end else if (!ena) begin
      m_trig = 0; m_err = 0; m_gap = '0;
      cand.delete();
    end else begin
      m_trig = 0; m_err = 0;
      if (cand.size() == 0) begin
        if (b) cand.push_back(1'b1);
        else if (m_gap != '1) m_gap = m_gap + 1'b1;
      end else begin
        cand.push_back(b);
        ok = 1;
        foreach (cand[i]) if (cand[i] != pat[i]) ok = 0;
        if (ok && cand.size() == 4) begin
          m_trig = 1;
          if (m_tc != '1) m_tc = m_tc + 1'b1;
          if (m_prior) begin m_lg = m_gap; m_gv = 1; end
          m_prior = 1; m_gap = '0;
          cand.delete();
        end else if (!ok) begin
          m_err = 1;
          if (m_ec != '1) m_ec = m_ec + 1'b1;
          m_gap = '0;
          cand.delete();
          if (b) cand.push_back(1'b1);
        end
      end
    end
    #1;
  endtask
  task automatic step(input bit b);
    stepx(b, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      stepx(1'($urandom), 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (act_v !== '0) begin n_errors++; $display("FAIL reset outputs got=%h want=0", act_v); end
    end
  endtask
  task automatic test_basic;
    int pulses = 0;
    stepx(0, 1, 1, 1);
    for (int h = 0; h < 3; h++) begin
      step(1); step(0); step(0);
      step(1);
      n_checks++;
      if (trig_out !== 1'b1) begin n_errors++; $display("FAIL basic_pulse_at_final got=%b want=1", trig_out); end
      pulses += trig_out;
      n_checks++;
      if (gap_valid !== (h > 0)) begin n_errors++; $display("FAIL basic_gap_valid hdr=%0d got=%b want=%b", h, gap_valid, h > 0); end
      for (int z = 0; z < 10; z++) begin
        step(0);
        pulses += trig_out;
        n_checks++;
        if (act_v !== exp_v) begin n_errors++; $display("FAIL basic_cycle got=%h want=%h", act_v, exp_v); end
      end
    end
    n_checks++;
    if ({pulses[7:0], trig_cnt, last_gap, gap_valid} !== {8'd3, CNT_W'(3), GAP_W'(10), 1'b1}) begin
      n_errors++; $display("FAIL basic_totals pulses=%0d cnt=%0d gap=%0d gv=%b want 3 3 10 1", pulses, trig_cnt, last_gap, gap_valid);
    end
  endtask
  task automatic test_errors;
    bit s[$] = '{1, 0, 0, 0, 1, 1, 0, 0, 1};
    int errs = 0;
    stepx(0, 1, 1, 1);
    foreach (s[i]) begin
      step(s[i]);
      errs += hdr_err;
      n_checks++;
      if (act_v !== exp_v) begin n_errors++; $display("FAIL errors_cycle%0d got=%h want=%h", i, act_v, exp_v); end
    end
    n_checks++;
    if ({errs[7:0], err_cnt, trig_cnt, gap_valid} !== {8'd2, CNT_W'(2), CNT_W'(1), 1'b0}) begin
      n_errors++; $display("FAIL errors_totals pulses=%0d ec=%0d tc=%0d gv=%b want 2 2 1 0", errs, err_cnt, trig_cnt, gap_valid);
    end
  endtask
  task automatic test_back_to_back;
    bit s[$] = '{1, 0, 0, 1, 1, 0, 0, 1};
    stepx(0, 1, 1, 1);
    foreach (s[i]) step(s[i]);
    n_checks++;
    if ({trig_cnt, last_gap, gap_valid, trig_out} !== {CNT_W'(2), GAP_W'(0), 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL b2b tc=%0d gap=%0d gv=%b trig=%b want 2 0 1 1", trig_cnt, last_gap, gap_valid, trig_out);
    end
  endtask
  task automatic test_live_drop;
    stepx(0, 1, 1, 1);
    step(1); step(1); step(0); step(0);
    stepx(1, 0, 1, 0);
    n_checks++;
    if (act_v !== '0) begin n_errors++; $display("FAIL live_drop_clear got=%h want=0", act_v); end
    step(0);
    n_checks++;
    if (trig_out !== 1'b0) begin n_errors++; $display("FAIL live_drop_no_pulse got=%b want=0", trig_out); end
    step(1); step(0); step(0); step(1);
    n_checks++;
    if ({trig_out, trig_cnt, err_cnt} !== {1'b1, CNT_W'(1), CNT_W'(0)}) begin
      n_errors++; $display("FAIL live_drop_after trig=%b tc=%0d ec=%0d want 1 1 0", trig_out, trig_cnt, err_cnt);
    end
  endtask
  task automatic test_ena_drop;
    stepx(0, 1, 1, 1);
    step(1); step(0); step(0); step(1);
    for (int i = 0; i < 4; i++) step(0);
    step(1); step(0); step(0); step(1);
    step(1); step(0); step(0);
    stepx(1, 1, 0, 0);
    n_checks++;
    if ({trig_out, hdr_err, trig_cnt, last_gap, gap_valid} !== {2'b00, CNT_W'(2), GAP_W'(4), 1'b1}) begin
      n_errors++; $display("FAIL ena_drop_discard trig=%b err=%b tc=%0d gap=%0d gv=%b want 0 0 2 4 1", trig_out, hdr_err, trig_cnt, last_gap, gap_valid);
    end
    for (int i = 0; i < 3; i++) step(0);
    step(1); step(0); step(0); step(1);
    n_checks++;
    if ({trig_cnt, last_gap} !== {CNT_W'(3), GAP_W'(3)}) begin
      n_errors++; $display("FAIL ena_drop_resume tc=%0d gap=%0d want 3 3", trig_cnt, last_gap);
    end
  endtask
  task automatic test_saturation;
    int last_pulses = 0;
    stepx(0, 1, 1, 1);
    for (int h = 0; h < 257; h++) begin
      step(1); step(0); step(0); step(1);
      if (h >= 255) last_pulses += trig_out;
    end
    n_checks++;
    if ({trig_cnt, last_pulses[3:0]} !== {CNT_W'('1), 4'd2}) begin
      n_errors++; $display("FAIL trig_sat tc=%0d pulses=%0d want %0d 2", trig_cnt, last_pulses, 2**CNT_W - 1);
    end
    for (int i = 0; i < 258; i++) step(1);
    n_checks++;
    if ({err_cnt, hdr_err} !== {CNT_W'('1), 1'b1}) begin
      n_errors++; $display("FAIL err_sat ec=%0d err=%b want %0d 1", err_cnt, hdr_err, 2**CNT_W - 1);
    end
    step(0); step(0); step(1);
    for (int i = 0; i < 40; i++) step(0);
    step(1); step(0); step(0); step(1);
    n_checks++;
    if (last_gap !== GAP_W'('1)) begin n_errors++; $display("FAIL gap_sat got=%0d want=%0d", last_gap, 2**GAP_W - 1); end
  endtask
  task automatic test_reset_mid;
    step(0); step(1); step(0); step(0);
    stepx(1, 1, 1, 1);
    n_checks++;
    if (act_v !== '0) begin n_errors++; $display("FAIL reset_mid got=%h want=0", act_v); end
    step(0);
    n_checks++;
    if (act_v !== '0) begin n_errors++; $display("FAIL reset_mid_after got=%h want=0", act_v); end
  endtask
  task automatic test_random;
    bit b;
    int gap;
    stepx(0, 1, 1, 1);
    for (int h = 0; h < 300; h++) begin
      gap = $urandom_range(0, 12);
      for (int k = 0; k < 4 + gap; k++) begin
        b = (k < 4) ? pat[k] : 1'b0;
        if ($urandom_range(0, 15) == 0) b = ~b;
        stepx(b, $urandom_range(0, 149) != 0, $urandom_range(0, 39) != 0, $urandom_range(0, 299) == 0);
        n_checks++;
        if (act_v !== exp_v) begin n_errors++; $display("FAIL random hdr=%0d got=%h want=%h", h, act_v, exp_v); end
      end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_errors;
    test_back_to_back;
    test_live_drop;
    test_ena_drop;
    test_saturation;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/delta_decoder.md
Name: delta_decoder

Overview:
Receive-side decoder for the serial delta-trigger line driven by the trigger generator.
- Detects the 4-cycle header pattern 1,0,0,1 on the sampled line and emits a one-cycle decoded trigger pulse.
- Counts valid triggers and flags malformed headers.
- Measures the idle gap (zero cycles) between consecutive headers.
- Sits in the top CDT receive path on the same clock as the generator, ahead of trigger-accounting logic.

Parameters:
CNT_W, 16, width of trigger and error counters
GAP_W, 32, width of gap measurement counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_live  input  1  run window; low = synchronous clear of FSM and counters
in_ena  input  1  decode enable; low = FSM held in IDLE, no detection
trig_in  input  1  serial trigger line, already synchronous to clk
trig_out  output  1  one-cycle pulse per valid header
hdr_err  output  1  one-cycle pulse per malformed header
trig_cnt  output  CNT_W  valid headers seen, saturating
err_cnt  output  CNT_W  malformed headers seen, saturating
last_gap  output  GAP_W  zero cycles between the previous header end and the latest header start
gap_valid  output  1  high once last_gap holds a real measurement

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset and priority:
  - reset=1 drives every output to 0 and puts the FSM in IDLE.
  - reset dominates in_live, which dominates in_ena.
- in_live=0 (not in reset): same clearing as reset.
- in_ena=0 (not in reset, in_live=1):
  - FSM forced to IDLE; trig_out and hdr_err are 0.
  - Counters, last_gap and gap_valid hold.
  - gap_run (internal) clears.
- FSM states: IDLE, S1, S10, S100. trig_in is sampled every clk.
  - IDLE: trig_in=1 -> S1. trig_in=0 -> stay in IDLE, gap_run+1 (saturates at all-ones).
  - S1: trig_in=0 -> S10. trig_in=1 -> hdr_err, stay in S1 (the new 1 is treated as a header start).
  - S10: trig_in=0 -> S100. trig_in=1 -> hdr_err, go to S1.
  - S100, trig_in=1 (valid header) -> IDLE, with:
    - trig_out=1 on the next cycle;
    - trig_cnt+1;
    - last_gap<=gap_run only if a prior header exists since clear, then gap_valid<=1;
    - gap_run<=0.
  - S100, trig_in=0 -> hdr_err, go to IDLE, gap_run<=0.
  - On every hdr_err, gap_run<=0. An errored header does not update last_gap and does not set "prior header exists".
- Latency: trig_out and hdr_err are registered. Each rises on the clk after the sample that completes or breaks the pattern, and lasts exactly 1 cycle.
- Gap measurement:
  - gap_run counts only IDLE cycles with trig_in=0.
  - The 1,0,0,1 header cycles are never counted.
  - A generator gap setting of N yields last_gap=N.
- First header after a clear:
  - trig_out pulses and trig_cnt increments.
  - last_gap is unchanged and gap_valid stays 0.
- Saturation: trig_cnt and err_cnt stop at all-ones; gap_run stops at all-ones. No wrap on any counter.
- Simultaneous events:
  - A valid header completing on the same cycle that in_ena falls is discarded.
  - reset or in_live=0 mid-header discards the partial header with no pulse.
- Back-to-back headers with gap 0 (1,0,0,1,1,0,0,1) decode as two valid triggers, last_gap=0.

Test Plan:
- Reset, in_live=1, in_ena=1; three headers separated by 10 zeros -> 3 trig_out pulses, each 1 cycle after the final 1; trig_cnt=3; last_gap=10; gap_valid set after the 2nd header.
- Stream 1,0,0,0 then 1,1,0,0,1 -> hdr_err pulses twice (at the 3rd zero and at the second 1); err_cnt=2; then one valid trigger, trig_cnt=1, gap_valid=0.
- Back-to-back headers with gap 0 -> trig_cnt=2, last_gap=0, gap_valid=1.
- Drop in_live to 0 after 1,0,0 -> no trig_out; all counters 0. Then a full header after in_live=1 -> trig_cnt=1.
- Preload via 65535 valid headers, then 2 more -> trig_cnt holds 16'hFFFF; trig_out still pulses for each.
- Assert reset on the final-1 cycle of a header -> trig_out stays 0; all outputs 0 on the next cycle.
